relu_share_arbiter: RTL and testbench

//  Shares a single registered saturating-ReLU activation stage among NUM_NEURONS accumulator outputs of one FNN layer.

---
 rtl/relu_share_arbiter.sv | 154 +++++++++++++++
 tb/tb_relu_share_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_share_arbiter.sv
// Round-robin share of one registered saturating-ReLU stage across a layer.
// Tags each result with its neuron index and pulses layer_done once all drain.
module relu_share_arbiter #(
  parameter  int NUM_NEURONS    = 4,
  parameter  int dataWidth      = 16,
  parameter  int weightIntWidth = 1,
  localparam int IDX_W          = $clog2(NUM_NEURONS)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_NEURONS-1:0]             req_valid,
  input  logic [NUM_NEURONS*2*dataWidth-1:0] req_data,
  output logic [NUM_NEURONS-1:0]             req_ready,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [dataWidth-1:0]               out_data,
  output logic [IDX_W-1:0]                   out_idx,
  output logic                               layer_done
);

  localparam int XW = 2 * dataWidth;

  typedef enum logic {
    ACTIVE,
    DRAIN
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_NEURONS-1:0] served_q, served_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic                   out_valid_q, out_valid_d;
  logic [dataWidth-1:0]   out_data_q, out_data_d;
  logic [IDX_W-1:0]       out_idx_q, out_idx_d;
  logic                   layer_done_q, layer_done_d;

  logic [NUM_NEURONS-1:0] eligible;
  logic [NUM_NEURONS-1:0] grant;
  logic [IDX_W-1:0]       gidx;
  logic                   found;
  logic [IDX_W:0]         scan;
  logic                   accept;
  logic                   hs;
  logic                   consume;
  logic [XW-1:0]          sel_x;

  function automatic logic [dataWidth-1:0] relu(input logic [XW-1:0] x);
    logic [dataWidth-1:0] r;
    if (x[XW-1]) begin
      r = '0;
    end else if (|x[XW-1 -: weightIntWidth]) begin
      r = {1'b0, {(dataWidth-1){1'b1}}};
    end else begin
      r = x[XW-weightIntWidth-1 -: dataWidth];
    end
    return r;
  endfunction

  assign eligible = req_valid & ~served_q;

  // Scan ptr, ptr+1, ... with wrap; first eligible requester wins.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    scan  = '0;
    for (int k = 0; k < NUM_NEURONS; k++) begin
      scan = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (scan >= (IDX_W+1)'(NUM_NEURONS)) begin
        scan = scan - (IDX_W+1)'(NUM_NEURONS);
      end
      if (!found && eligible[scan[IDX_W-1:0]]) begin
        found                    = 1'b1;
        grant[scan[IDX_W-1:0]]   = 1'b1;
        gidx                     = scan[IDX_W-1:0];
      end
    end
  end

  assign accept    = ~out_valid_q | out_ready;
  assign hs        = out_valid_q & out_ready;
  assign req_ready = grant & {NUM_NEURONS{accept & rst_n & (state_q == ACTIVE)}};
  assign consume   = |req_ready;
  assign sel_x     = req_data[gidx*XW +: XW];

  always_comb begin
    state_d      = state_q;
    served_d     = served_q;
    ptr_d        = ptr_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_idx_d    = out_idx_q;
    layer_done_d = 1'b0;

    unique case (state_q)
      ACTIVE: begin
        if (consume) begin
          served_d = served_q | grant;
          if (gidx == IDX_W'(NUM_NEURONS-1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = gidx + 1'b1;
          end
          if (&served_d) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Final result leaving closes the layer; no grant this cycle.
        if (hs) begin
          served_d     = '0;
          ptr_d        = '0;
          layer_done_d = 1'b1;
          state_d      = ACTIVE;
        end
      end
      default: state_d = ACTIVE;
    endcase

    if (consume) begin
      out_valid_d = 1'b1;
      out_data_d  = relu(sel_x);
      out_idx_d   = gidx;
    end else if (hs) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ACTIVE;
      served_q     <= '0;
      ptr_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_idx_q    <= '0;
      layer_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      served_q     <= served_d;
      ptr_q        <= ptr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_idx_q    <= out_idx_d;
      layer_done_q <= layer_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_idx    = out_idx_q;
  assign layer_done = layer_done_q;

endmodule

// File: tb/tb_relu_share_arbiter.sv
// Scoreboard bench for relu_share_arbiter: directed grants, backpressure,
// layer boundaries, fairness, mid-layer reset and ReLU arithmetic.
module tb_relu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [127:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_idx;
  logic        layer_done;

  logic [3:0]   req_valid_s;
  logic [127:0] req_data_s;
  logic [3:0]   req_ready_s;
  logic         out_valid_s;
  logic         out_ready_s;
  logic [15:0]  out_data_s;
  logic [1:0]   out_idx_s;
  logic         layer_done_s;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [1:0]  idx;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];

  relu_share_arbiter #(
    .NUM_NEURONS(4), .dataWidth(16), .weightIntWidth(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .layer_done(layer_done)
  );

  relu_share_arbiter #(
    .NUM_NEURONS(4), .dataWidth(16), .weightIntWidth(2)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_s), .req_data(req_data_s), .req_ready(req_ready_s),
    .out_valid(out_valid_s), .out_ready(out_ready_s),
    .out_data(out_data_s), .out_idx(out_idx_s), .layer_done(layer_done_s)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_empty: got idx %0d data %h expected none at %0t",
                 out_idx, out_data, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_idx", 32'(out_idx), 32'(e.idx));
        chk("out_data", 32'(out_data), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [3:0] er);
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(er));
    tick();
  endtask

  task automatic push(input logic [1:0] i, input logic [15:0] d);
    exp_t e;
    e.idx  = i;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic set_x(input int i, input logic [31:0] x);
    req_data[i*32 +: 32] = x;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    fails++;
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    req_valid   = 4'hF;
    req_data    = '0;
    out_ready   = 1'b1;
    req_valid_s = 4'b0001;
    req_data_s  = '0;
    req_data_s[31:0] = 32'h4000_0000;
    out_ready_s = 1'b1;
    set_x(0, 32'h0800_0000);
    set_x(1, 32'hFFFF_FFFF);
    set_x(2, 32'h0000_0000);
    set_x(3, 32'h0001_8000);
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_layer_done", 32'(layer_done), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    #4;
    rst_n = 1'b1;

    // back-to-back grants 0..3
    push(2'd0, 16'h1000);
    push(2'd1, 16'h0000);
    push(2'd2, 16'h0000);
    push(2'd3, 16'h0003);
    for (int i = 0; i < 4; i++) begin
      cyc(4'(1 << i));
      if (i == 0) begin
        chk("sat_valid", 32'(out_valid_s), 32'd1);
        chk("sat_data", 32'(out_data_s), 32'h7FFF);
      end
    end
    @(negedge clk);
    chk("drain_req_ready", 32'(req_ready), 32'd0);
    chk("drain_layer_done", 32'(layer_done), 32'd0);
    tick();
    req_valid = 4'h0;
    @(negedge clk);
    chk("ld_pulse1", 32'(layer_done), 32'd1);
    tick();
    @(negedge clk);
    chk("ld_clear1", 32'(layer_done), 32'd0);
    tick();

    // backpressure, then fairness past the pointer
    set_x(1, 32'h0002_0000);
    set_x(2, 32'h8000_0000);
    req_valid = 4'b0001;
    out_ready = 1'b0;
    push(2'd0, 16'h1000);
    cyc(4'b0001);
    req_valid = 4'b1001;
    repeat (5) begin
      @(negedge clk);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_idx", 32'(out_idx), 32'd0);
      chk("bp_data", 32'(out_data), 32'h1000);
      tick();
    end
    out_ready = 1'b1;
    push(2'd3, 16'h0003);
    cyc(4'b1000);
    req_valid = 4'b0110;
    push(2'd1, 16'h0004);
    cyc(4'b0010);
    push(2'd2, 16'h0000);
    cyc(4'b0100);
    @(negedge clk);
    chk("hs_cycle_no_grant", 32'(req_ready), 32'd0);
    chk("hs_cycle_ld", 32'(layer_done), 32'd0);
    tick();

    // neuron 2 served alone, re-asserts, waits for next layer
    req_valid = 4'b0100;
    push(2'd2, 16'h0000);
    @(negedge clk);
    chk("ld_pulse2", 32'(layer_done), 32'd1);
    chk("resume_grant", 32'(req_ready), 32'b0100);
    tick();
    repeat (3) cyc(4'b0000);
    req_valid = 4'hF;
    push(2'd3, 16'h0003);
    cyc(4'b1000);
    push(2'd0, 16'h1000);
    cyc(4'b0001);
    push(2'd1, 16'h0004);
    cyc(4'b0010);
    @(negedge clk);
    chk("drain2_req_ready", 32'(req_ready), 32'd0);
    chk("drain2_ld", 32'(layer_done), 32'd0);
    tick();
    req_valid = 4'b0100;
    push(2'd2, 16'h0000);
    @(negedge clk);
    chk("ld_pulse3", 32'(layer_done), 32'd1);
    chk("regrant2", 32'(req_ready), 32'b0100);
    tick();

    // reset mid-layer with a pending output
    req_valid = 4'b0001;
    cyc(4'b0001);
    out_ready = 1'b0;
    req_valid = 4'h0;
    @(negedge clk);
    chk("pend_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n     = 1'b0;
    req_valid = 4'hF;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    chk("arst_idx", 32'(out_idx), 32'd0);
    chk("arst_ld", 32'(layer_done), 32'd0);
    chk("arst_req_ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    req_valid = 4'b0010;
    push(2'd1, 16'h0004);
    cyc(4'b0010);
    req_valid = 4'b1001;
    push(2'd3, 16'h0003);
    cyc(4'b1000);
    push(2'd0, 16'h1000);
    cyc(4'b0001);
    req_valid = 4'b0100;
    push(2'd2, 16'h0000);
    @(negedge clk);
    chk("post_rst_rr2", 32'(req_ready), 32'b0100);
    chk("post_rst_ld0", 32'(layer_done), 32'd0);
    tick();
    req_valid = 4'h0;
    @(negedge clk);
    chk("post_rst_ld_hs", 32'(layer_done), 32'd0);
    tick();
    @(negedge clk);
    chk("ld_pulse4", 32'(layer_done), 32'd1);
    tick();
    @(negedge clk);
    chk("ld_clear4", 32'(layer_done), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
